// File: rtl/channel_pkg.sv
// Shared definitions for the channel initial-selection sequence: result codes,
// FSM state encoding and bus parity helpers. The mock control unit uses this too.
package channel_pkg;

  localparam logic [2:0] RESULT_OK            = 3'd0;
  localparam logic [2:0] RESULT_NO_DEVICE     = 3'd1;
  localparam logic [2:0] RESULT_ADDR_MISMATCH = 3'd2;
  localparam logic [2:0] RESULT_PARITY        = 3'd3;
  localparam logic [2:0] RESULT_TIMEOUT       = 3'd4;

  // Inbound bundle: bus_in[7:0], bus_in_parity, operational_in, address_in,
  // status_in, select_in.
  localparam int SYNC_WIDTH = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SELECT,
    ST_CMD,
    ST_STATUS,
    ST_ACCEPT
  } state_t;

  // Parity bit that makes {b, bit} contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // True when the byte and its parity bit together carry odd parity.
  function automatic logic parity_good(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/channel_initial_selection_if.sv
// Channel bus and tag lines between the channel (master) and a control unit (slave).
interface channel_initial_selection_if;

  logic [7:0] bus_out;
  logic       bus_out_parity;
  logic       operational_out;
  logic       hold_out;
  logic       select_out;
  logic       address_out;
  logic       command_out;
  logic       service_out;
  logic       suppress_out;

  logic [7:0] bus_in;
  logic       bus_in_parity;
  logic       operational_in;
  logic       address_in;
  logic       status_in;
  logic       select_in;
  logic       service_in;
  logic       request_in;

  modport master (
    output bus_out, bus_out_parity, operational_out, hold_out, select_out,
           address_out, command_out, service_out, suppress_out,
    input  bus_in, bus_in_parity, operational_in, address_in, status_in,
           select_in, service_in, request_in
  );

  modport slave (
    input  bus_out, bus_out_parity, operational_out, hold_out, select_out,
           address_out, command_out, service_out, suppress_out,
    output bus_in, bus_in_parity, operational_in, address_in, status_in,
           select_in, service_in, request_in
  );

endinterface

// File: rtl/channel_input_sync.sv
// Two-flop synchronizer over a parameterised-width bundle of inbound lines.
module channel_input_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Each bit gets its own two-stage chain; bits are not treated as a coherent word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/channel_initial_selection.sv
// Channel-side initiator of the bus-and-tag initial selection sequence:
// address a control unit, send one command byte, collect the status byte.
module channel_initial_selection
  import channel_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [3:0]  SETTLE_CYCLES  = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] device_address,
  input  logic [7:0] command,
  output logic       busy,
  output logic       done,
  output logic [2:0] result,
  output logic [7:0] status_byte,
  channel_initial_selection_if.master ch
);

  // Synchronized view of the inbound bus and tags.
  logic [SYNC_WIDTH-1:0] sync_raw;
  logic [SYNC_WIDTH-1:0] sync_val;
  logic [7:0]            s_bus;
  logic                  s_par;
  logic                  s_op;
  logic                  s_addr;
  logic                  s_status;
  logic                  s_select;

  assign sync_raw = {ch.bus_in, ch.bus_in_parity, ch.operational_in,
                     ch.address_in, ch.status_in, ch.select_in};

  channel_input_sync #(.WIDTH(SYNC_WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sync_raw),
    .q     (sync_val)
  );

  assign {s_bus, s_par, s_op, s_addr, s_status, s_select} = sync_val;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic        parity_q, parity_d;
  logic        oper_q, oper_d;
  logic        hold_q, hold_d;
  logic        select_q, select_d;
  logic        address_out_q, address_out_d;
  logic        command_out_q, command_out_d;
  logic        service_q, service_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  result_q, result_d;
  logic [7:0]  status_q, status_d;

  logic        finish;
  logic [2:0]  finish_code;
  logic        timeout_hit;
  logic        settle_hit;
  logic        in_parity_ok;

  // The timer restarts at every state change, so its value is time spent in the current state.
  assign timeout_hit  = (timer_q == (TIMEOUT_CYCLES - 16'd1));
  assign settle_hit   = (timer_q == {12'd0, SETTLE_CYCLES - 4'd1});
  assign in_parity_ok = parity_good(s_bus, s_par);

  // Next-state and next-output logic of the selection sequence.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cmd_d         = cmd_q;
    bus_out_d     = bus_out_q;
    hold_d        = hold_q;
    select_d      = select_q;
    address_out_d = address_out_q;
    command_out_d = command_out_q;
    service_d     = service_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_d      = result_q;
    status_d      = status_q;
    oper_d        = 1'b1;
    finish        = 1'b0;
    finish_code   = RESULT_OK;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d        = device_address;
          cmd_d         = command;
          bus_out_d     = device_address;
          address_out_d = 1'b1;
          busy_d        = 1'b1;
          result_d      = RESULT_OK;
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (settle_hit) begin
          hold_d   = 1'b1;
          select_d = 1'b1;
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // select_in coming back means nobody claimed the address; it wins over address_in.
        if (s_select) begin
          finish      = 1'b1;
          finish_code = RESULT_NO_DEVICE;
        end else if (s_op && s_addr) begin
          if (!in_parity_ok) begin
            finish      = 1'b1;
            finish_code = RESULT_PARITY;
          end else if (s_bus != addr_q) begin
            finish      = 1'b1;
            finish_code = RESULT_ADDR_MISMATCH;
          end else begin
            address_out_d = 1'b0;
            bus_out_d     = cmd_q;
            command_out_d = 1'b1;
            state_d       = ST_CMD;
          end
        end else if (timeout_hit) begin
          finish      = 1'b1;
          finish_code = RESULT_TIMEOUT;
        end
      end
      ST_CMD: begin
        if (!s_addr) begin
          command_out_d = 1'b0;
          hold_d        = 1'b0;
          select_d      = 1'b0;
          bus_out_d     = 8'h00;
          state_d       = ST_STATUS;
        end else if (timeout_hit) begin
          finish      = 1'b1;
          finish_code = RESULT_TIMEOUT;
        end
      end
      ST_STATUS: begin
        if (s_status) begin
          if (!in_parity_ok) begin
            finish      = 1'b1;
            finish_code = RESULT_PARITY;
          end else begin
            status_d  = s_bus;
            service_d = 1'b1;
            state_d   = ST_ACCEPT;
          end
        end else if (timeout_hit) begin
          finish      = 1'b1;
          finish_code = RESULT_TIMEOUT;
        end
      end
      ST_ACCEPT: begin
        if (!s_status) begin
          finish      = 1'b1;
          finish_code = RESULT_OK;
        end else if (timeout_hit) begin
          finish      = 1'b1;
          finish_code = RESULT_TIMEOUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every ending, good or bad, leaves the bus idle with only operational_out up.
    if (finish) begin
      hold_d        = 1'b0;
      select_d      = 1'b0;
      address_out_d = 1'b0;
      command_out_d = 1'b0;
      service_d     = 1'b0;
      bus_out_d     = 8'h00;
      result_d      = finish_code;
      done_d        = 1'b1;
      busy_d        = 1'b0;
      state_d       = ST_IDLE;
    end

    timer_d  = (state_d != state_q) ? 16'd0 : timer_q + 16'd1;
    parity_d = odd_parity(bus_out_d);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      addr_q        <= '0;
      cmd_q         <= '0;
      bus_out_q     <= '0;
      parity_q      <= 1'b0;
      oper_q        <= 1'b0;
      hold_q        <= 1'b0;
      select_q      <= 1'b0;
      address_out_q <= 1'b0;
      command_out_q <= 1'b0;
      service_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= RESULT_OK;
      status_q      <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      addr_q        <= addr_d;
      cmd_q         <= cmd_d;
      bus_out_q     <= bus_out_d;
      parity_q      <= parity_d;
      oper_q        <= oper_d;
      hold_q        <= hold_d;
      select_q      <= select_d;
      address_out_q <= address_out_d;
      command_out_q <= command_out_d;
      service_q     <= service_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      status_q      <= status_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign result             = result_q;
  assign status_byte        = status_q;
  assign ch.bus_out         = bus_out_q;
  assign ch.bus_out_parity  = parity_q;
  assign ch.operational_out = oper_q;
  assign ch.hold_out        = hold_q;
  assign ch.select_out      = select_q;
  assign ch.address_out     = address_out_q;
  assign ch.command_out     = command_out_q;
  assign ch.service_out     = service_q;
  assign ch.suppress_out    = 1'b0;

endmodule

// File: tb/tb_channel_initial_selection.sv
// Bench for channel_initial_selection: a behavioural control unit answers each
// selection, expected outcomes are queued at start and checked on done.
module tb_channel_initial_selection;
  import channel_pkg::*;

  localparam int M_OK       = 0;
  localparam int M_NODEV    = 1;
  localparam int M_ECHO     = 2;
  localparam int M_SILENT   = 3;
  localparam int M_RESET    = 4;
  localparam int WAIT_LIMIT = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] device_address = 8'h00;
  logic [7:0] command = 8'h00;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic [7:0] status_byte;

  channel_initial_selection_if ch();

  channel_initial_selection #(
    .TIMEOUT_CYCLES (16'd16),
    .SETTLE_CYCLES  (4'd2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .device_address (device_address),
    .command        (command),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .status_byte    (status_byte),
    .ch             (ch.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;
    logic [7:0] st;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   sel_cyc = 0;
  bit   sel_seen = 0;
  bit   saw_cmd = 0;
  bit   saw_srv = 0;

  always @(posedge clk) cyc++;

  // Sticky observations of outbound tags across a transaction.
  always @(negedge clk) begin
    if (ch.command_out) saw_cmd = 1'b1;
    if (ch.service_out) saw_srv = 1'b1;
    if (ch.select_out && !sel_seen) begin
      sel_seen = 1'b1;
      sel_cyc  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inbound();
    ch.bus_in         = 8'h00;
    ch.bus_in_parity  = 1'b1;
    ch.operational_in = 1'b0;
    ch.address_in     = 1'b0;
    ch.status_in      = 1'b0;
    ch.select_in      = 1'b0;
    ch.service_in     = 1'b0;
    ch.request_in     = 1'b0;
  endtask

  function automatic logic [28:0] all_outputs();
    return {busy, done, result, status_byte, ch.bus_out, ch.bus_out_parity,
            ch.operational_out, ch.hold_out, ch.select_out, ch.address_out,
            ch.command_out, ch.service_out, ch.suppress_out};
  endfunction

  // Behavioural control unit for one selection.
  task automatic responder(input int mode, input logic [7:0] echo, input bit echo_bad,
                           input logic [7:0] cmd_exp, input logic [7:0] stat, input bit stat_bad);
    bit got;
    got = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !got; i++) begin
      @(negedge clk);
      got = ch.select_out;
    end
    if (!got || mode == M_SILENT) return;
    if (mode == M_NODEV) begin
      repeat (3) @(negedge clk);
      ch.select_in = 1'b1;
      for (int i = 0; i < WAIT_LIMIT && ch.select_out; i++) @(negedge clk);
      clear_inbound();
      return;
    end
    ch.bus_in         = echo;
    ch.bus_in_parity  = echo_bad ? ^echo : ~^echo;
    ch.operational_in = 1'b1;
    ch.address_in     = 1'b1;
    got = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge clk);
      if (ch.command_out) begin
        got = 1'b1;
        break;
      end
      if (!ch.select_out) break;
    end
    if (!got) begin
      clear_inbound();
      return;
    end
    check("cmd_byte", ch.bus_out, cmd_exp);
    check("cmd_parity", ch.bus_out_parity, ~^cmd_exp);
    ch.address_in    = 1'b0;
    ch.bus_in        = 8'h00;
    ch.bus_in_parity = 1'b1;
    for (int i = 0; i < WAIT_LIMIT && ch.select_out; i++) @(negedge clk);
    ch.bus_in        = stat;
    ch.bus_in_parity = stat_bad ? ^stat : ~^stat;
    ch.status_in     = 1'b1;
    got = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(negedge clk);
      if (ch.service_out) begin
        got = 1'b1;
        break;
      end
      if (!busy) break;
    end
    if (got && mode == M_RESET) begin
      reset = 1'b1;
      #1;
      check("reset_async_outputs", all_outputs(), 29'd0);
      clear_inbound();
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    ch.status_in     = 1'b0;
    ch.bus_in        = 8'h00;
    ch.bus_in_parity = 1'b1;
    if (got) for (int i = 0; i < WAIT_LIMIT && ch.service_out; i++) @(negedge clk);
    clear_inbound();
  endtask

  // Waits for done, pops the scoreboard and checks the end-of-sequence state.
  task automatic watch_done();
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1'b1);
    e = sb_q.pop_front();
    if (!got) return;
    check("result", result, e.res);
    if (e.res == RESULT_OK) check("status_byte", status_byte, e.st);
    if (e.res == RESULT_TIMEOUT) check("timeout_cycles", cyc - sel_cyc, 16);
    check("busy_at_done", busy, 1'b0);
    check("tags_at_done", {ch.address_out, ch.select_out, ch.hold_out, ch.command_out,
                           ch.service_out, ch.suppress_out, ch.operational_out}, 7'b0000001);
    check("bus_at_done", {ch.bus_out, ch.bus_out_parity}, 9'h001);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic run_txn(input string name, input int mode, input logic [7:0] addr,
                         input logic [7:0] cmd, input logic [7:0] echo, input bit echo_bad,
                         input logic [7:0] stat, input bit stat_bad, input logic [2:0] exp_res,
                         input bit exp_cmd, input bit exp_srv);
    int   start_cyc;
    exp_t e;
    e.res = exp_res;
    e.st  = stat;
    if (mode != M_RESET) sb_q.push_back(e);
    saw_cmd  = 1'b0;
    saw_srv  = 1'b0;
    sel_seen = 1'b0;
    @(negedge clk);
    start          = 1'b1;
    device_address = addr;
    command        = cmd;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
    check("start_busy", busy, 1'b1);
    check("start_address_out", {ch.address_out, ch.bus_out}, {1'b1, addr});
    if (mode == M_RESET) begin
      responder(mode, echo, echo_bad, cmd, stat, stat_bad);
    end else begin
      fork
        responder(mode, echo, echo_bad, cmd, stat, stat_bad);
        watch_done();
      join
      check("command_out_seen", saw_cmd, exp_cmd);
      check("service_out_seen", saw_srv, exp_srv);
    end
    check("settle_delay", sel_cyc - start_cyc, 2);
    $display("txn %s: result=%0d status=%02h busy=%0d", name, result, status_byte, busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inbound();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 29'd0);
    reset = 1'b0;
    @(negedge clk);
    check("operational_after_reset", {ch.operational_out, ch.bus_out_parity, busy}, 3'b110);

    run_txn("happy",        M_OK,     8'h40, 8'h02, 8'h40, 1'b0, 8'h0C, 1'b0, RESULT_OK,            1'b1, 1'b1);
    run_txn("no_device",    M_NODEV,  8'h40, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, RESULT_NO_DEVICE,     1'b0, 1'b0);
    run_txn("mismatch",     M_ECHO,   8'h40, 8'h02, 8'h41, 1'b0, 8'h00, 1'b0, RESULT_ADDR_MISMATCH, 1'b0, 1'b0);
    run_txn("addr_parity",  M_ECHO,   8'h40, 8'h02, 8'h41, 1'b1, 8'h00, 1'b0, RESULT_PARITY,        1'b0, 1'b0);
    run_txn("stat_parity",  M_OK,     8'h40, 8'h02, 8'h40, 1'b0, 8'h0C, 1'b1, RESULT_PARITY,        1'b1, 1'b0);
    run_txn("timeout",      M_SILENT, 8'h40, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, RESULT_TIMEOUT,       1'b0, 1'b0);
    run_txn("reset_accept", M_RESET,  8'h40, 8'h02, 8'h40, 1'b0, 8'h0C, 1'b0, RESULT_OK,            1'b1, 1'b1);
    run_txn("after_reset",  M_OK,     8'hA5, 8'h3C, 8'hA5, 1'b0, 8'h81, 1'b0, RESULT_OK,            1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
